wombat_command_issuer_uart: RTL and testbench

- Host-side initiator for the wombat UART register protocol. It is the far end of the wombat command parser.
- Accepts one write or read command per handshake and serializes it as a REG_WIDTH+2 word frame on o_tx.
- For reads, collects the REG_WIDTH-word response arriving on i_rx and presents it as one register value.
- Used in loopback benches and FPGA-to-FPGA links that drive a wombat command parser.

---
 rtl/wombat_command_issuer_uart.sv | 268 ++++++++++++++++++++++++++
 tb/tb_wombat_command_issuer_uart.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wombat_command_issuer_uart.sv
// Host-side initiator for the wombat UART register protocol: serializes write/read command frames
// on o_tx and assembles the read response arriving on i_rx.
module wombat_command_issuer_uart #(
   parameter int unsigned WORD_WIDTH         = 8,
   parameter int unsigned DIVISOR            = 100,
   parameter int unsigned SAMPLE_PHASE       = 49,
   parameter int unsigned REG_WIDTH          = 4,
   parameter int unsigned UART_LITTLE_ENDIAN = 1,
   parameter int unsigned LITTLE_ENDIAN      = 0,
   parameter int unsigned TIMEOUT            = 65535,
   parameter logic [WORD_WIDTH-1:0] CMD_WRITE = WORD_WIDTH'(1),
   parameter logic [WORD_WIDTH-1:0] CMD_READ  = WORD_WIDTH'(2)
) (
   input  logic                            clk,
   input  logic                            i_reset,
   input  logic                            i_valid,
   output logic                            o_ready,
   input  logic                            i_rw,
   input  logic [WORD_WIDTH-1:0]           i_addr,
   input  logic [REG_WIDTH*WORD_WIDTH-1:0] i_value,
   output logic                            o_tx,
   input  logic                            i_rx,
   output logic [REG_WIDTH*WORD_WIDTH-1:0] o_r_value,
   output logic                            o_r_valid,
   output logic                            o_timeout,
   output logic                            o_busy
);

   localparam int unsigned NWORDS  = REG_WIDTH + 2;
   localparam int unsigned FRAME_W = NWORDS * WORD_WIDTH;
   localparam int unsigned RV_W    = REG_WIDTH * WORD_WIDTH;
   localparam int unsigned DIV_W   = $clog2(DIVISOR);
   localparam int unsigned BIT_W   = $clog2(WORD_WIDTH + 2);
   localparam int unsigned WIDX_W  = $clog2(NWORDS);
   localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);
   localparam int unsigned RCNT_W  = $clog2(REG_WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

   state_e              state_q, state_d;
   logic [FRAME_W-1:0]  frame_q, frame_d;
   logic                is_write_q, is_write_d;
   logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
   logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic                tx_q, tx_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
   logic [RV_W-1:0]     r_value_q, r_value_d;
   logic [RV_W-1:0]     r_saved_q, r_saved_d;
   logic                r_valid_q, r_valid_d;
   logic                timeout_q, timeout_d;

   logic [1:0]            rx_sync_q, rx_sync_d;
   logic                  rx_busy_q, rx_busy_d;
   logic [DIV_W-1:0]      rx_div_q, rx_div_d;
   logic [BIT_W-1:0]      rx_bit_q, rx_bit_d;
   logic [WORD_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_dv_q, rx_dv_d;
   logic                  rx_dv_prev_q;
   logic                  rx_in;
   logic                  rx_stb;

   logic [FRAME_W-1:0]    frame_msw;
   logic [FRAME_W-1:0]    frame_new;
   logic [WORD_WIDTH-1:0] cur_word;
   logic                  data_bit;
   logic [RV_W-1:0]       r_shifted;

   assign rx_in  = rx_sync_q[1];
   assign rx_stb = rx_dv_q & ~rx_dv_prev_q;

   // Frame as sent with word0 in the top slot; LITTLE_ENDIAN reverses the word order.
   always_comb begin
      frame_msw = {(i_rw ? CMD_WRITE : CMD_READ), i_addr, (i_rw ? i_value : {RV_W{1'b0}})};
      frame_new = frame_msw;
      if (LITTLE_ENDIAN != 0) begin
         for (int k = 0; k < NWORDS; k++) begin
            frame_new[k*WORD_WIDTH +: WORD_WIDTH] =
               frame_msw[(NWORDS-1-k)*WORD_WIDTH +: WORD_WIDTH];
         end
      end
   end

   always_comb begin
      cur_word = frame_q[FRAME_W-1 -: WORD_WIDTH];
      data_bit = 1'b1;
      for (int k = 0; k < WORD_WIDTH; k++) begin
         if (int'(bit_idx_q) == k) begin
            data_bit = (UART_LITTLE_ENDIAN != 0) ? cur_word[k] : cur_word[WORD_WIDTH-1-k];
         end
      end
      if (LITTLE_ENDIAN != 0) begin
         r_shifted = (r_value_q >> WORD_WIDTH) | (RV_W'(rx_data_q) << (RV_W - WORD_WIDTH));
      end else begin
         r_shifted = (r_value_q << WORD_WIDTH) | RV_W'(rx_data_q);
      end
   end

   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      is_write_d = is_write_q;
      word_idx_d = word_idx_q;
      bit_idx_d  = bit_idx_q;
      div_d      = div_q;
      tx_d       = tx_q;
      to_cnt_d   = to_cnt_q;
      rcnt_d     = rcnt_q;
      r_value_d  = r_value_q;
      r_saved_d  = r_saved_q;
      r_valid_d  = 1'b0;
      timeout_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (i_valid) begin
               state_d    = StSend;
               frame_d    = frame_new;
               is_write_d = i_rw;
               word_idx_d = '0;
               bit_idx_d  = '0;
               div_d      = '0;
               tx_d       = 1'b0;
            end
         end
         StSend: begin
            if (div_q == DIV_W'(DIVISOR - 1)) begin
               div_d = '0;
               if (bit_idx_q == BIT_W'(WORD_WIDTH + 1)) begin
                  if (word_idx_q == WIDX_W'(NWORDS - 1)) begin
                     state_d  = is_write_q ? StIdle : StWait;
                     tx_d     = 1'b1;
                     to_cnt_d = '0;
                     rcnt_d   = '0;
                  end else begin
                     word_idx_d = word_idx_q + WIDX_W'(1);
                     bit_idx_d  = '0;
                     frame_d    = frame_q << WORD_WIDTH;
                     tx_d       = 1'b0;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + BIT_W'(1);
                  // Next bit is data index bit_idx_q, or the stop bit after the last data bit.
                  tx_d = (bit_idx_q == BIT_W'(WORD_WIDTH)) ? 1'b1 : data_bit;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         StWait: begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (to_cnt_q == TO_W'(TIMEOUT)) begin
               state_d = StIdle;
            end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
               // Timeout wins over a coincident word; partial words are rolled back.
               timeout_d = 1'b1;
               r_value_d = r_saved_q;
            end else if (rx_stb) begin
               r_value_d = r_shifted;
               if (rcnt_q == RCNT_W'(REG_WIDTH - 1)) begin
                  r_valid_d = 1'b1;
                  r_saved_d = r_shifted;
                  state_d   = StIdle;
               end else begin
                  rcnt_d = rcnt_q + RCNT_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Receiver: two-flop synchronizer, start-bit qualify, mid-bit sampling, stop-bit check.
   always_comb begin
      rx_sync_d = {rx_sync_q[0], i_rx};
      rx_busy_d = rx_busy_q;
      rx_div_d  = rx_div_q;
      rx_bit_d  = rx_bit_q;
      rx_data_d = rx_data_q;
      rx_dv_d   = 1'b0;
      if (!rx_busy_q) begin
         if (!rx_in) begin
            rx_busy_d = 1'b1;
            rx_div_d  = '0;
            rx_bit_d  = '0;
         end
      end else begin
         if (rx_div_q == DIV_W'(DIVISOR - 1)) begin
            rx_div_d = '0;
            rx_bit_d = rx_bit_q + BIT_W'(1);
         end else begin
            rx_div_d = rx_div_q + DIV_W'(1);
         end
         if (rx_div_q == DIV_W'(SAMPLE_PHASE)) begin
            if (rx_bit_q == '0) begin
               rx_busy_d = ~rx_in;
            end else if (rx_bit_q <= BIT_W'(WORD_WIDTH)) begin
               rx_data_d = (UART_LITTLE_ENDIAN != 0) ?
                  ((rx_data_q >> 1) | (WORD_WIDTH'(rx_in) << (WORD_WIDTH - 1))) :
                  ((rx_data_q << 1) | WORD_WIDTH'(rx_in));
            end else begin
               rx_busy_d = 1'b0;
               rx_dv_d   = rx_in;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= StIdle;
         frame_q    <= '0;
         is_write_q <= 1'b0;
         word_idx_q <= '0;
         bit_idx_q  <= '0;
         div_q      <= '0;
         tx_q       <= 1'b1;
         to_cnt_q   <= '0;
         rcnt_q     <= '0;
         r_value_q  <= '0;
         r_saved_q  <= '0;
         r_valid_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         is_write_q <= is_write_d;
         word_idx_q <= word_idx_d;
         bit_idx_q  <= bit_idx_d;
         div_q      <= div_d;
         tx_q       <= tx_d;
         to_cnt_q   <= to_cnt_d;
         rcnt_q     <= rcnt_d;
         r_value_q  <= r_value_d;
         r_saved_q  <= r_saved_d;
         r_valid_q  <= r_valid_d;
         timeout_q  <= timeout_d;
      end
   end

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         rx_sync_q    <= 2'b11;
         rx_busy_q    <= 1'b0;
         rx_div_q     <= '0;
         rx_bit_q     <= '0;
         rx_data_q    <= '0;
         rx_dv_q      <= 1'b0;
         rx_dv_prev_q <= 1'b0;
      end else begin
         rx_sync_q    <= rx_sync_d;
         rx_busy_q    <= rx_busy_d;
         rx_div_q     <= rx_div_d;
         rx_bit_q     <= rx_bit_d;
         rx_data_q    <= rx_data_d;
         rx_dv_q      <= rx_dv_d;
         rx_dv_prev_q <= rx_dv_q;
      end
   end

   assign o_ready   = (state_q == StIdle);
   assign o_busy    = ~o_ready;
   assign o_tx      = tx_q;
   assign o_r_value = r_value_q;
   assign o_r_valid = r_valid_q;
   assign o_timeout = timeout_q;

endmodule

// File: tb/tb_wombat_command_issuer_uart.sv
// Directed bench for wombat_command_issuer_uart: frame timing, read responses, timeout,
// back-to-back commands, async reset and stray rx words.
module tb_wombat_command_issuer_uart;

   localparam int D  = 10;
   localparam int TO = 2000;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic        i_rw = 1'b0;
   logic [7:0]  i_addr = 8'h00;
   logic [31:0] i_value = 32'h0;
   logic        o_tx;
   logic        i_rx = 1'b1;
   logic [31:0] o_r_value;
   logic        o_r_valid;
   logic        o_timeout;
   logic        o_busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rv_cnt = 0;
   int to_cnt = 0;
   int both_cnt = 0;
   logic [7:0] exp_w [6];

   wombat_command_issuer_uart #(
      .WORD_WIDTH(8), .DIVISOR(D), .SAMPLE_PHASE(4), .REG_WIDTH(4),
      .UART_LITTLE_ENDIAN(1), .LITTLE_ENDIAN(0), .TIMEOUT(TO),
      .CMD_WRITE(8'h01), .CMD_READ(8'h02)
   ) dut (
      .clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready), .i_rw(i_rw),
      .i_addr(i_addr), .i_value(i_value), .o_tx(o_tx), .i_rx(i_rx), .o_r_value(o_r_value),
      .o_r_valid(o_r_valid), .o_timeout(o_timeout), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_r_valid) rv_cnt++;
      if (o_timeout) to_cnt++;
      if (o_r_valid && o_timeout) both_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
      cyc += n;
   endtask

   task automatic goto(input int t);
      if (t > cyc) tick(t - cyc);
   endtask

   task automatic set_exp(input logic [7:0] a0, a1, a2, a3, a4, a5);
      exp_w[0] = a0; exp_w[1] = a1; exp_w[2] = a2;
      exp_w[3] = a3; exp_w[4] = a4; exp_w[5] = a5;
   endtask

   // Issue a command; cyc becomes 0 on the cycle right after the accepting edge.
   task automatic accept(input logic rw, input logic [7:0] a, input logic [31:0] v,
                         input bit hold);
      checks++;
      if (o_ready !== 1'b1) begin
         errors++; $display("FAIL accept_ready: got %b expected 1", o_ready);
      end
      i_valid = 1'b1; i_rw = rw; i_addr = a; i_value = v;
      tick(1);
      cyc = 0;
      if (!hold) i_valid = 1'b0;
      checks++;
      if (o_ready !== 1'b0) begin
         errors++; $display("FAIL ready_drop: got %b expected 0", o_ready);
      end
   endtask

   // Sample every bit mid-way; word w, bit b occupies cycles (w*10+b)*D .. +D-1.
   task automatic check_frame(input string name);
      logic [9:0] got;
      logic [9:0] exp;
      for (int w = 0; w < 6; w++) begin
         for (int b = 0; b < 10; b++) begin
            goto(w*10*D + b*D + D/2);
            got[b] = o_tx;
         end
         exp = {1'b1, exp_w[w], 1'b0};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s word%0d: got %03h expected %03h", name, w, got, exp);
         end
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      i_rx = 1'b0; tick(D);
      for (int k = 0; k < 8; k++) begin
         i_rx = b[k]; tick(D);
      end
      i_rx = 1'b1; tick(D);
   endtask

   task automatic test_reset;
      i_reset = 1'b1;
      tick(3);
      i_reset = 1'b0;
      tick(2);
      checks++; if (o_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", o_tx); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
      checks++; if (o_r_value !== 32'h0) begin errors++; $display("FAIL reset_rvalue: got %h expected 0", o_r_value); end
      checks++; if (o_r_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", o_r_valid); end
      checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", o_timeout); end
   endtask

   task automatic test_write;
      set_exp(8'h01, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
      accept(1'b1, 8'h05, 32'hDEADBEEF, 1'b0);
      check_frame("write");
      goto(599);
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL write_ready_599: got %b expected 0", o_ready); end
      goto(600);
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL write_ready_600: got %b expected 1", o_ready); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL write_busy_600: got %b expected 0", o_busy); end
      checks++; if (o_tx !== 1'b1) begin errors++; $display("FAIL write_tx_idle: got %b expected 1", o_tx); end
   endtask

   task automatic test_read;
      int r0;
      r0 = rv_cnt;
      set_exp(8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00);
      accept(1'b0, 8'h03, 32'hFFFFFFFF, 1'b0);
      check_frame("read");
      goto(600);
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL read_wait_busy: got %b expected 1", o_busy); end
      send_rx(8'h12); send_rx(8'h34); send_rx(8'h56); send_rx(8'h78);
      tick(20);
      checks++; if (rv_cnt - r0 != 1) begin errors++; $display("FAIL read_rvalid_pulses: got %0d expected 1", rv_cnt - r0); end
      checks++; if (o_r_value !== 32'h12345678) begin errors++; $display("FAIL read_value: got %h expected 12345678", o_r_value); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL read_ready: got %b expected 1", o_ready); end
   endtask

   task automatic test_timeout;
      int r0;
      int t0;
      r0 = rv_cnt; t0 = to_cnt;
      set_exp(8'h02, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00);
      accept(1'b0, 8'h07, 32'h0, 1'b0);
      check_frame("timeout_frame");
      goto(600);
      send_rx(8'hAB); send_rx(8'hCD);
      goto(600 + TO - 1);
      checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", o_timeout); end
      goto(600 + TO);
      checks++; if (o_timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b expected 1", o_timeout); end
      checks++; if (o_r_value !== 32'h12345678) begin errors++; $display("FAIL timeout_value: got %h expected 12345678", o_r_value); end
      goto(600 + TO + 1);
      checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL timeout_width: got %b expected 0", o_timeout); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready: got %b expected 1", o_ready); end
      checks++; if (to_cnt - t0 != 1) begin errors++; $display("FAIL timeout_count: got %0d expected 1", to_cnt - t0); end
      checks++; if (rv_cnt - r0 != 0) begin errors++; $display("FAIL timeout_no_rvalid: got %0d expected 0", rv_cnt - r0); end
   endtask

   task automatic test_back_to_back;
      set_exp(8'h01, 8'h11, 8'h01, 8'h02, 8'h03, 8'h04);
      accept(1'b1, 8'h11, 32'h01020304, 1'b1);
      i_addr = 8'h22; i_value = 32'hA5A55A5A;  // changes while busy must not reach frame A
      check_frame("b2b_first");
      for (int k = 590; k <= 600; k++) begin
         goto(k);
         checks++; if (o_tx !== 1'b1) begin errors++; $display("FAIL b2b_gap_%0d: got %b expected 1", k, o_tx); end
      end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", o_ready); end
      goto(601);
      cyc = 0;
      i_valid = 1'b0;
      checks++; if (o_tx !== 1'b0) begin errors++; $display("FAIL b2b_start: got %b expected 0", o_tx); end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b expected 0", o_ready); end
      set_exp(8'h01, 8'h22, 8'hA5, 8'hA5, 8'h5A, 8'h5A);
      check_frame("b2b_second");
      goto(600);
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_end_ready: got %b expected 1", o_ready); end
   endtask

   task automatic test_async_reset;
      int r0;
      int t0;
      r0 = rv_cnt; t0 = to_cnt;
      accept(1'b1, 8'h33, 32'hCAFEF00D, 1'b0);
      goto(302);
      checks++; if (o_tx !== 1'b0) begin errors++; $display("FAIL rst_pre_tx: got %b expected 0", o_tx); end
      #2 i_reset = 1'b1;
      #1;
      checks++; if (o_tx !== 1'b1) begin errors++; $display("FAIL rst_async_tx: got %b expected 1", o_tx); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", o_ready); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", o_busy); end
      checks++; if (o_r_value !== 32'h0) begin errors++; $display("FAIL rst_rvalue: got %h expected 0", o_r_value); end
      tick(2);
      i_reset = 1'b0;
      tick(1);
      checks++; if (rv_cnt != r0 || to_cnt != t0) begin errors++; $display("FAIL rst_no_pulse: got %0d/%0d expected %0d/%0d", rv_cnt, to_cnt, r0, t0); end
      set_exp(8'h01, 8'h44, 8'h0B, 8'hAD, 8'hCA, 8'hFE);
      accept(1'b1, 8'h44, 32'h0BADCAFE, 1'b0);
      check_frame("rst_after");
      goto(600);
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_after_ready: got %b expected 1", o_ready); end
   endtask

   task automatic test_stray_rx;
      int r0;
      r0 = rv_cnt;
      send_rx(8'hAA);
      tick(10);
      checks++; if (rv_cnt != r0) begin errors++; $display("FAIL stray_rvalid: got %0d expected %0d", rv_cnt, r0); end
      checks++; if (o_r_value !== 32'h0) begin errors++; $display("FAIL stray_value: got %h expected 0", o_r_value); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL stray_ready: got %b expected 1", o_ready); end
      set_exp(8'h02, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00);
      accept(1'b0, 8'h09, 32'h0, 1'b0);
      check_frame("stray_read");
      goto(600);
      send_rx(8'h11); send_rx(8'h22); send_rx(8'h33); send_rx(8'h44);
      tick(20);
      checks++; if (rv_cnt - r0 != 1) begin errors++; $display("FAIL stray_read_pulses: got %0d expected 1", rv_cnt - r0); end
      checks++; if (o_r_value !== 32'h11223344) begin errors++; $display("FAIL stray_read_value: got %h expected 11223344", o_r_value); end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_back_to_back();
      test_async_reset();
      test_stray_rx();
      checks++;
      if (both_cnt != 0) begin
         errors++; $display("FAIL rvalid_timeout_overlap: got %0d expected 0", both_cnt);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
